// File: rtl/dac_delay_driver.sv
`default_nettype none
// ============================================================================
// Module      : dac_delay_driver
// Description : Per-channel DAC output stage. Substitutes an idle/bias value
//               when the experiment FSM sample is not valid, delays the
//               sample stream by a programmable number of clocks, and expands
//               each sample into an SPP-lane AXI-Stream word for the DAC.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: DAC_DRV_RAMP_EN
//   defined   : lanes linearly interpolate from the previous to the current
//               output value (lane SPP-1 equals the current value).
//   undefined : every lane carries the current value (zero-order hold).
// ----------------------------------------------------------------------------
// Ports
//   clk            in   sole clock
//   rst            in   asynchronous, active-low reset
//   din            in   num_bits  sample from the experiment FSM
//   din_valid      in   din qualifier
//   idle_val       in   num_bits  value used when din_valid=0 (quasi-static)
//   del_cfg        in   8  requested delay in clocks
//   del_cfg_load   in   one-cycle pulse, latches del_cfg
//   m_axis_tdata   out  SPP*num_bits DAC word, lane 0 played first
//   m_axis_tvalid  out  stream valid (1 from the first clock after reset)
//   m_axis_tready  in   DAC ready
//   cur_del        out  8  delay currently in effect
//   drop_cnt       out  16 saturating count of words presented while not ready
//   cfg_err        out  sticky, a load requested a delay >= MAX_DEL
// ============================================================================
module dac_delay_driver #(
    parameter int num_bits = 16,
    parameter int SPP      = 4,
    parameter int MAX_DEL  = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [num_bits-1:0]     din,
    input  logic                    din_valid,
    input  logic [num_bits-1:0]     idle_val,
    input  logic [7:0]              del_cfg,
    input  logic                    del_cfg_load,
    output logic [SPP*num_bits-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [7:0]              cur_del,
    output logic [15:0]             drop_cnt,
    output logic                    cfg_err
);

    localparam int         AW        = (MAX_DEL > 1) ? $clog2(MAX_DEL) : 1;
    localparam logic [8:0] C_MAX_DEL = 9'(MAX_DEL);

    // Input capture stage; reset makes the first post-reset sample idle.
    logic [num_bits-1:0]     din_q;
    logic                    din_valid_q;

    logic [num_bits-1:0]     dly_mem_q [MAX_DEL];
    logic [AW-1:0]           wp_q,     wp_d;
    logic [AW-1:0]           del_q,    del_d;
    logic [AW-1:0]           fill_q,   fill_d;
    logic                    cfg_err_q, cfg_err_d;
    logic [15:0]             drop_q,   drop_d;
    logic                    tvalid_q;
    logic [SPP*num_bits-1:0] tdata_q,  tdata_d;

    logic [num_bits-1:0]     sel_s;
    logic [num_bits-1:0]     v;
    logic [AW:0]             rd_sum;
    logic [AW-1:0]           rd_addr;
    logic [num_bits-1:0]     lane_w [SPP];

    always_comb begin
        sel_s = din_valid_q ? din_q : idle_val;

        // Entry written del_q clocks ago, modulo the buffer depth.
        rd_sum  = {1'b0, wp_q} + (AW+1)'(MAX_DEL) - {1'b0, del_q};
        rd_addr = (rd_sum >= (AW+1)'(MAX_DEL)) ? AW'(rd_sum - (AW+1)'(MAX_DEL))
                                               : AW'(rd_sum);

        // D=0 bypasses the buffer so the current write is seen directly.
        if (fill_q != '0) begin
            v = idle_val;
        end else if (del_q == '0) begin
            v = sel_s;
        end else begin
            v = dly_mem_q[rd_addr];
        end

        wp_d = (wp_q == AW'(MAX_DEL-1)) ? '0 : wp_q + AW'(1);

        del_d     = del_q;
        fill_d    = (fill_q != '0) ? fill_q - AW'(1) : fill_q;
        cfg_err_d = cfg_err_q;
        if (del_cfg_load) begin
            if ({1'b0, del_cfg} >= C_MAX_DEL) begin
                del_d     = AW'(MAX_DEL-1);
                cfg_err_d = 1'b1;
            end else begin
                del_d     = AW'(del_cfg);
            end
            // A new load restarts the idle fill with the newest delay.
            fill_d = del_d;
        end

        drop_d = drop_q;
        if (tvalid_q && !m_axis_tready && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

`ifdef DAC_DRV_RAMP_EN
    localparam int LOG2_SPP = (SPP > 1) ? $clog2(SPP) : 0;

    logic [num_bits-1:0]   prev_v_q;
    logic signed [num_bits:0] diff_w;

    assign diff_w = $signed({v[num_bits-1], v}) - $signed({prev_v_q[num_bits-1], prev_v_q});

    for (genvar k = 0; k < SPP; k++) begin : g_lane
        logic signed [num_bits+5:0] prod_w;
        logic signed [num_bits+5:0] shr_w;
        assign prod_w    = (num_bits+6)'(diff_w) * $signed((num_bits+6)'(k+1));
        assign shr_w     = prod_w >>> LOG2_SPP;
        // Result lies between prev and current value, so truncation is exact.
        assign lane_w[k] = prev_v_q + shr_w[num_bits-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_v_q <= '0;
        end else begin
            prev_v_q <= v;
        end
    end
`else
    for (genvar k = 0; k < SPP; k++) begin : g_lane
        assign lane_w[k] = v;
    end
`endif

    for (genvar k = 0; k < SPP; k++) begin : g_pack
        assign tdata_d[k*num_bits +: num_bits] = lane_w[k];
    end

    // Delay line storage needs no reset: every location read is written first.
    always_ff @(posedge clk) begin
        dly_mem_q[wp_q] <= sel_s;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_q       <= '0;
            din_valid_q <= 1'b0;
            wp_q        <= '0;
            del_q       <= '0;
            fill_q      <= '0;
            cfg_err_q   <= 1'b0;
            drop_q      <= '0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
        end else begin
            din_q       <= din;
            din_valid_q <= din_valid;
            wp_q        <= wp_d;
            del_q       <= del_d;
            fill_q      <= fill_d;
            cfg_err_q   <= cfg_err_d;
            drop_q      <= drop_d;
            tvalid_q    <= 1'b1;
            tdata_q     <= tdata_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign cur_del       = 8'(del_q);
    assign drop_cnt      = drop_q;
    assign cfg_err       = cfg_err_q;

endmodule
`default_nettype wire
